life_ctrl: RTL and testbench
============================

LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 Parameter: none; all widths fixed for the 8x8 life grid (64 cells, row r = grid[8r+7:8r]).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces all state to reset values immediately.
REQ-004 start  in  1  level; high = run generations continuously, low = stop.
REQ-005 step  in  1  single-cycle request for exactly one generation while idle.
REQ-006 randomize  in  1  request to reseed the grid from the internal LFSR.
REQ-007 speed  in  4  generation period minus 1, in clk cycles (0 = every cycle, 15 = every 16).
REQ-008 grid  in  64  current grid from the life engine; engine updates it the cycle after adv.
REQ-009 adv  out  1  one-cycle pulse: engine computes next generation.
REQ-010 load  out  1  one-cycle pulse: engine loads seed into grid.
REQ-011 seed  out  64  registered seed pattern, valid while load is high, held afterwards.
REQ-012 gen_count  out  16  generations issued since the last reseed/reset, saturating.
REQ-013 extinct  out  1  sticky: grid became all-zero after an adv.
REQ-014 stable  out  1  sticky: grid unchanged across an adv.
REQ-015 state  out  2  FSM state: 0 IDLE, 1 SEED, 2 RUN, 3 HALT.

Function
REQ-016 FSM SHALL have states IDLE, SEED, RUN, HALT; priority within a state: randomize > start > step.
REQ-017 IDLE: randomize -> SEED; else start -> RUN with divider cleared; else step -> adv=1 for that cycle, remain IDLE.
REQ-018 SEED SHALL last exactly one cycle: load=1, seed<=LFSR, gen_count<=0, extinct<=0, stable<=0, next state IDLE.
REQ-019 RUN: 4-bit divider increments each cycle; when divider==speed, adv=1 and divider<=0; first adv occurs speed+1 cycles after entry.
REQ-020 RUN: start low -> IDLE next cycle, no adv in that cycle; randomize in RUN SHALL be ignored.
REQ-021 RUN: extinct or stable set -> HALT next cycle; no adv issued in HALT.
REQ-022 HALT: randomize -> SEED; else start low -> IDLE; step ignored.
REQ-023 speed change mid-RUN takes effect at next comparison; if divider>speed, divider wraps through 15 to 0 before next adv.
REQ-024 adv and load SHALL never be high in the same cycle.
REQ-025 gen_count SHALL increment on every adv (RUN or step), saturating at 16'hFFFF.
REQ-026 On each adv, snapshot<=grid; one cycle later (chk), stable<=1 if grid==snapshot, extinct<=1 if grid==0.
REQ-027 extinct/stable SHALL remain set until SEED or reset; step-induced adv also updates them.
REQ-028 LFSR: 64-bit Fibonacci, shifts left every cycle, feedback bit0 = b63^b62^b60^b59; if all-zero, next value 64'h1.
REQ-029 seed SHALL change only in SEED.

Reset
REQ-030 On reset: state=IDLE, adv=0, load=0, seed=0, gen_count=0, extinct=0, stable=0, divider=0, snapshot=0, chk=0, LFSR=64'hACE1_0000_0000_ACE1.
REQ-031 Reset asserted mid-RUN or mid-SEED SHALL abort immediately with no adv/load pulse after assertion.
REQ-032 First adv/load possible on the first rising edge after reset deasserts.

Verification
REQ-033 Reset, speed=0, start=1, grid driven by a blinker model -> adv every cycle from second cycle, gen_count counts 1,2,3..., stable stays 0.
REQ-034 speed=3, start=1 for 20 cycles -> exactly 5 adv pulses spaced 4 cycles, gen_count=5; start=0 -> IDLE next cycle.
REQ-035 randomize=1 in IDLE -> state SEED for one cycle, load=1, seed=nonzero LFSR value, gen_count=0; randomize during RUN -> no load.
REQ-036 Engine model returns grid=0 after an adv in RUN -> extinct=1 at chk, state HALT, no further adv; randomize -> SEED clears extinct.
REQ-037 Engine returns unchanged block pattern 64'h0000_0018_1800_0000 after adv -> stable=1, HALT; start=0 -> IDLE; step pulse -> one adv, gen_count+1.
REQ-038 Assert reset 2 cycles into RUN with speed=0 -> all outputs at reset values same cycle, no adv until start reasserted.

Source files
------------

// File: rtl/life_ctrl.sv
// Controller for an 8x8 life engine: sequences seeding from an internal LFSR,
// free-running or single-step generations, and extinction/stability detection.
module life_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic        randomize,
  input  logic [3:0]  speed,
  input  logic [63:0] grid,
  output logic        adv,
  output logic        load,
  output logic [63:0] seed,
  output logic [15:0] gen_count,
  output logic        extinct,
  output logic        stable,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSeed = 2'd1,
    StRun  = 2'd2,
    StHalt = 2'd3
  } state_e;

  localparam logic [63:0] LfsrInit = 64'hACE1_0000_0000_ACE1;

  state_e      state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [63:0] lfsr_q, lfsr_d;
  logic [63:0] seed_q, seed_d;
  logic [63:0] snap_q, snap_d;
  logic [15:0] gen_q, gen_d;
  logic        ext_q, ext_d;
  logic        stab_q, stab_d;
  logic        chk_q, chk_d;
  logic        reseed;
  logic        lfsr_fb;

  // Next-state logic and the adv/load pulses (adv is Mealy on start/step/speed).
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    load    = 1'b0;
    div_d   = 4'd0;
    unique case (state_q)
      StIdle: begin
        if (randomize) begin
          state_d = StSeed;
        end else if (start) begin
          state_d = StRun;
        end else if (step) begin
          adv = 1'b1;
        end
      end
      StSeed: begin
        load    = 1'b1;
        state_d = StIdle;
      end
      StRun: begin
        // randomize is deliberately not looked at here
        if (!start) begin
          state_d = StIdle;
        end else if (ext_q || stab_q) begin
          state_d = StHalt;
        end else if (div_q == speed) begin
          adv = 1'b1;
        end else begin
          // a divider above a freshly lowered speed wraps through 15 to 0
          div_d = div_q + 4'd1;
        end
      end
      StHalt: begin
        if (randomize) begin
          state_d = StSeed;
        end else if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: LFSR, seed capture, snapshot/check and sticky flags.
  always_comb begin
    reseed  = (state_d == StSeed) || (state_q == StSeed);
    lfsr_fb = lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59];
    lfsr_d  = (lfsr_q == 64'd0) ? 64'd1 : {lfsr_q[62:0], lfsr_fb};
    seed_d  = (state_d == StSeed) ? lfsr_q : seed_q;
    snap_d  = adv ? grid : snap_q;
    chk_d   = adv;
    gen_d   = gen_q;
    ext_d   = ext_q;
    stab_d  = stab_q;
    if (reseed) begin
      gen_d  = 16'd0;
      ext_d  = 1'b0;
      stab_d = 1'b0;
    end else begin
      if (adv && (gen_q != 16'hFFFF)) begin
        gen_d = gen_q + 16'd1;
      end
      // grid reflects the generation computed on the previous adv
      if (chk_q && (grid == 64'd0)) begin
        ext_d = 1'b1;
      end
      if (chk_q && (grid == snap_q)) begin
        stab_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= 4'd0;
      lfsr_q  <= LfsrInit;
      seed_q  <= 64'd0;
      snap_q  <= 64'd0;
      gen_q   <= 16'd0;
      ext_q   <= 1'b0;
      stab_q  <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      snap_q  <= snap_d;
      gen_q   <= gen_d;
      ext_q   <= ext_d;
      stab_q  <= stab_d;
      chk_q   <= chk_d;
    end
  end

  assign seed      = seed_q;
  assign gen_count = gen_q;
  assign extinct   = ext_q;
  assign stable    = stab_q;
  assign state     = state_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl with a small life-engine model and LFSR model.
module tb_life_ctrl;

  localparam logic [63:0] Vert     = 64'h0000_0008_0808_0000;
  localparam logic [63:0] Horz     = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] Blk      = 64'h0000_0018_1800_0000;
  localparam logic [63:0] LfsrInit = 64'hACE1_0000_0000_ACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic        randomize = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic [63:0] grid = 64'd0;
  logic        adv, load;
  logic [63:0] seed;
  logic [15:0] gen_count;
  logic        extinct, stable;
  logic [1:0]  state;

  int          n_chk = 0;
  int          n_pass = 0;
  int          adv_cnt = 0;
  int          base;
  int          mode = 0;        // engine: 0 blinker, 1 dies, 2 still life
  logic        force_en = 1'b0;
  logic [63:0] force_val = 64'd0;
  logic        adv_n = 1'b0, load_n = 1'b0;
  logic [63:0] seed_n = 64'd0;
  logic [63:0] m_lfsr, m_prev, exp_seed;

  life_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (step),
    .randomize (randomize),
    .speed     (speed),
    .grid      (grid),
    .adv       (adv),
    .load      (load),
    .seed      (seed),
    .gen_count (gen_count),
    .extinct   (extinct),
    .stable    (stable),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Capture the controller's pulses mid-cycle so the engine acts on them cleanly.
  always @(negedge clk) begin
    adv_n  <= adv;
    load_n <= load;
    seed_n <= seed;
    if (adv) adv_cnt <= adv_cnt + 1;
  end

  // Life engine model.
  always @(posedge clk) begin
    if (force_en) grid <= force_val;
    else if (load_n) grid <= seed_n;
    else if (adv_n) begin
      case (mode)
        0:       grid <= (grid == Vert) ? Horz : Vert;
        1:       grid <= 64'd0;
        default: grid <= grid;
      endcase
    end
  end

  function automatic logic [63:0] lfsr_next(input logic [63:0] v);
    if (v == 64'd0) return 64'd1;
    return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
  endfunction

  // Reference LFSR; m_prev is the value that was current before the last edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= LfsrInit;
      m_prev <= 64'd0;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " state"}, 64'(state), 64'd0);
    check({tag, " adv"}, 64'(adv), 64'd0);
    check({tag, " load"}, 64'(load), 64'd0);
    check({tag, " seed"}, seed, 64'd0);
    check({tag, " gen"}, 64'(gen_count), 64'd0);
    check({tag, " extinct"}, 64'(extinct), 64'd0);
    check({tag, " stable"}, 64'(stable), 64'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(); tick(); #1;
    check_reset_vals("rst");
    reset = 1'b0; force_en = 1'b1; force_val = Vert;
    tick(); force_en = 1'b0; #1;

    // Continuous run at speed 0 with a blinker
    tick(); start = 1'b1; speed = 4'd0; mode = 0; #1;
    check("run0 idle state", 64'(state), 64'd0);
    check("run0 idle adv", 64'(adv), 64'd0);
    for (int i = 1; i <= 6; i++) begin
      tick(); #1;
      check("run0 state", 64'(state), 64'd2);
      check("run0 adv", 64'(adv), 64'd1);
      check("run0 gen", 64'(gen_count), 64'(i - 1));
      check("run0 stable", 64'(stable), 64'd0);
    end
    tick(); start = 1'b0; #1;
    check("stop adv", 64'(adv), 64'd0);
    check("stop gen", 64'(gen_count), 64'd6);
    tick(); #1;
    check("stop state", 64'(state), 64'd0);
    check("stop gen2", 64'(gen_count), 64'd6);

    // speed=3: adv every 4th RUN cycle
    base = adv_cnt;
    tick(); speed = 4'd3; start = 1'b1; #1;
    for (int i = 1; i <= 20; i++) begin
      tick(); #1;
      check("spd3 adv", 64'(adv), 64'((i % 4) == 0));
    end
    tick(); start = 1'b0; #1;
    check("spd3 stop adv", 64'(adv), 64'd0);
    tick(); #1;
    check("spd3 state", 64'(state), 64'd0);
    check("spd3 gen", 64'(gen_count), 64'd11);
    check("spd3 count", 64'(adv_cnt - base), 64'd5);

    // Lower speed below the divider mid-run: divider wraps through 15
    tick(); speed = 4'd3; start = 1'b1; #1;
    tick(); #1; check("wrap adv d0", 64'(adv), 64'd0);
    tick(); #1; check("wrap adv d1", 64'(adv), 64'd0);
    tick(); speed = 4'd1; #1; check("wrap adv d2", 64'(adv), 64'd0);
    for (int i = 4; i <= 18; i++) begin
      tick(); #1;
      check("wrap adv", 64'(adv), 64'(i == 18));
    end
    tick(); start = 1'b0; #1;
    check("wrap gen", 64'(gen_count), 64'd12);
    tick(); #1;
    check("wrap state", 64'(state), 64'd0);

    // Reseed from IDLE; randomize outranks start and step
    tick(); randomize = 1'b1; start = 1'b1; step = 1'b1; #1;
    check("rnd prio adv", 64'(adv), 64'd0);
    check("rnd prio load", 64'(load), 64'd0);
    tick(); randomize = 1'b0; start = 1'b0; step = 1'b0; #1;
    exp_seed = m_prev;
    check("seed state", 64'(state), 64'd1);
    check("seed load", 64'(load), 64'd1);
    check("seed adv", 64'(adv), 64'd0);
    check("seed gen", 64'(gen_count), 64'd0);
    check("seed value", seed, exp_seed);
    check("seed nonzero", 64'(seed != 64'd0), 64'd1);
    tick(); #1;
    check("post seed state", 64'(state), 64'd0);
    check("post seed load", 64'(load), 64'd0);

    // randomize ignored in RUN
    tick(); start = 1'b1; speed = 4'd15; #1;
    tick(); randomize = 1'b1; #1;
    check("run rnd state", 64'(state), 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("run rnd state", 64'(state), 64'd2);
      check("run rnd load", 64'(load), 64'd0);
    end
    tick(); randomize = 1'b0; start = 1'b0; #1;
    check("seed held", seed, exp_seed);
    tick(); #1;
    check("run rnd exit", 64'(state), 64'd0);

    // Extinction halts the run; reseed clears it
    tick(); force_en = 1'b1; force_val = Vert; mode = 1; #1;
    tick(); force_en = 1'b0; start = 1'b1; speed = 4'd0; #1;
    tick(); #1;
    check("ext g1 adv", 64'(adv), 64'd1);
    tick(); #1;
    check("ext g2 extinct", 64'(extinct), 64'd0);
    tick(); #1;
    check("ext g3 extinct", 64'(extinct), 64'd1);
    check("ext g3 adv", 64'(adv), 64'd0);
    tick(); #1;
    check("ext halt state", 64'(state), 64'd3);
    check("ext halt adv", 64'(adv), 64'd0);
    check("ext halt gen", 64'(gen_count), 64'd2);
    tick(); step = 1'b1; #1;
    check("halt step adv", 64'(adv), 64'd0);
    tick(); step = 1'b0; randomize = 1'b1; #1;
    check("halt state", 64'(state), 64'd3);
    tick(); randomize = 1'b0; start = 1'b0; #1;
    check("ext reseed state", 64'(state), 64'd1);
    check("ext reseed load", 64'(load), 64'd1);
    check("ext cleared", 64'(extinct), 64'd0);
    check("ext stable cleared", 64'(stable), 64'd0);
    check("ext gen cleared", 64'(gen_count), 64'd0);
    tick(); #1;
    check("ext idle", 64'(state), 64'd0);

    // Still life (block) sets stable and halts; step still works from IDLE
    tick(); force_en = 1'b1; force_val = Blk; mode = 2; #1;
    tick(); force_en = 1'b0; start = 1'b1; speed = 4'd0; #1;
    tick(); #1;
    check("blk h1 adv", 64'(adv), 64'd1);
    tick(); #1;
    check("blk h2 stable", 64'(stable), 64'd0);
    tick(); #1;
    check("blk h3 stable", 64'(stable), 64'd1);
    check("blk h3 extinct", 64'(extinct), 64'd0);
    check("blk h3 adv", 64'(adv), 64'd0);
    tick(); start = 1'b0; #1;
    check("blk halt", 64'(state), 64'd3);
    check("blk gen", 64'(gen_count), 64'd2);
    tick(); #1;
    check("blk idle", 64'(state), 64'd0);
    tick(); step = 1'b1; #1;
    check("step adv", 64'(adv), 64'd1);
    check("step state", 64'(state), 64'd0);
    tick(); step = 1'b0; #1;
    check("step adv off", 64'(adv), 64'd0);
    check("step gen", 64'(gen_count), 64'd3);
    check("step stable sticky", 64'(stable), 64'd1);

    // Reset two cycles into RUN
    tick(); randomize = 1'b1; mode = 0; #1;
    tick(); randomize = 1'b0; #1;
    tick(); start = 1'b1; speed = 4'd0; #1;
    check("pre rst stable", 64'(stable), 64'd0);
    tick(); #1;
    check("rr j1 adv", 64'(adv), 64'd1);
    tick(); #1;
    check("rr j2 adv", 64'(adv), 64'd1);
    reset = 1'b1; #1;
    check_reset_vals("midrun rst");
    tick(); #1;
    check("rst held adv", 64'(adv), 64'd0);
    tick(); reset = 1'b0; start = 1'b0; #1;
    check("post rst adv", 64'(adv), 64'd0);
    tick(); #1;
    check("post rst state", 64'(state), 64'd0);
    check("post rst adv2", 64'(adv), 64'd0);
    tick(); start = 1'b1; #1;
    check("restart idle", 64'(state), 64'd0);
    tick(); #1;
    check("restart state", 64'(state), 64'd2);
    check("restart adv", 64'(adv), 64'd1);
    check("restart gen", 64'(gen_count), 64'd0);
    tick(); start = 1'b0; #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
